// File: rtl/mem_wb_pkg.sv
// Shared constants for the MEM/WB pipeline register: reset polarity, widths, stall-vector bit positions.
package mem_wb_pkg;

  localparam logic        RstEnable  = 1'b0;
  localparam logic        RstDisable = 1'b1;
  localparam logic [31:0] ZeroWord   = 32'h0000_0000;
  localparam int          RegNumLog2 = 5;

  localparam int STALL_MEM = 4;
  localparam int STALL_WB  = 5;

endpackage

// File: rtl/mem_wb_llbit.sv
// LLbit register for LL/SC. It clears on reset or flush and loads from WB.
// The output bypasses a WB write in the same cycle.
module mem_wb_llbit
  import mem_wb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic wb_llbit_we,
  input  logic wb_llbit_value,
  output logic llbit
);

  logic llbit_q;

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      llbit_q <= 1'b0;
    end else if (flush) begin
      llbit_q <= 1'b0;
    end else if (wb_llbit_we) begin
      llbit_q <= wb_llbit_value;
    end
  end

  assign llbit = wb_llbit_we ? wb_llbit_value : llbit_q;

endmodule

// File: rtl/mem_wb.sv
// MEM->WB pipeline register with stall/bubble/flush handling and a retired-instruction counter.
// Optional LLbit support is enabled by defining MEM_WB_LLBIT_EN.
module mem_wb
  import mem_wb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = RegNumLog2,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] mem_wd,
  input  logic              mem_wreg,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_whilo,
  input  logic [DATA_W-1:0] mem_hi,
  input  logic [DATA_W-1:0] mem_lo,
  input  logic              mem_valid,
  output logic [ADDR_W-1:0] wb_wd,
  output logic              wb_wreg,
  output logic [DATA_W-1:0] wb_wdata,
  output logic              wb_whilo,
  output logic [DATA_W-1:0] wb_hi,
  output logic [DATA_W-1:0] wb_lo,
  output logic [CNT_W-1:0]  retired
`ifdef MEM_WB_LLBIT_EN
  ,
  input  logic              mem_llbit_we,
  input  logic              mem_llbit_value,
  output logic              wb_llbit_we,
  output logic              wb_llbit_value,
  output logic              llbit
`endif
);

  logic [ADDR_W-1:0] wd_q;
  logic              wreg_q;
  logic [DATA_W-1:0] wdata_q;
  logic              whilo_q;
  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;
  logic              valid_q;
  logic [CNT_W-1:0]  retired_q;

  logic capture;
  logic bubble;

  // Only the MEM and WB stall bits matter at this boundary.
  logic unused_stall;
  assign unused_stall = ^stall[3:0];

  assign bubble  = flush || (stall[STALL_MEM] && !stall[STALL_WB]);
  assign capture = !stall[STALL_MEM];

`ifdef MEM_WB_LLBIT_EN
  logic ll_we_q;
  logic ll_val_q;

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      ll_we_q  <= 1'b0;
      ll_val_q <= 1'b0;
    end else if (bubble) begin
      ll_we_q  <= 1'b0;
      ll_val_q <= 1'b0;
    end else if (capture) begin
      ll_we_q  <= mem_llbit_we;
      ll_val_q <= mem_llbit_value;
    end
  end

  assign wb_llbit_we    = ll_we_q & valid_q;
  assign wb_llbit_value = ll_val_q;

  mem_wb_llbit u_llbit (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .wb_llbit_we    (wb_llbit_we),
    .wb_llbit_value (wb_llbit_value),
    .llbit          (llbit)
  );
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      wd_q      <= '0;
      wreg_q    <= 1'b0;
      wdata_q   <= '0;
      whilo_q   <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      valid_q   <= 1'b0;
      retired_q <= '0;
    end else if (bubble) begin
      wd_q    <= '0;
      wreg_q  <= 1'b0;
      wdata_q <= '0;
      whilo_q <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      valid_q <= 1'b0;
    end else if (capture) begin
      wd_q    <= mem_wd;
      wreg_q  <= mem_wreg;
      wdata_q <= mem_wdata;
      whilo_q <= mem_whilo;
      hi_q    <= mem_hi;
      lo_q    <= mem_lo;
      valid_q <= mem_valid;
      if (mem_valid) begin
        retired_q <= retired_q + CNT_W'(1);
      end
    end
  end

  // Write enables are qualified by valid so a captured non-instruction never commits.
  assign wb_wd    = wd_q;
  assign wb_wreg  = wreg_q & valid_q;
  assign wb_wdata = wdata_q;
  assign wb_whilo = whilo_q & valid_q;
  assign wb_hi    = hi_q;
  assign wb_lo    = lo_q;
  assign retired  = retired_q;

endmodule
